// File: rtl/fpu_ss_rd_scoreboard.sv
// Destination-register / offload-ID scoreboard for the FPU subsystem controller.
// Saturating per-register pending-write counters, RAW/WAW hazard detection, forwarding select, commit table.
module fpu_ss_rd_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int MAX_PENDING = 3,
    parameter int NUM_WB      = 2,
    parameter int ID_WIDTH    = 4,
    parameter int FORWARDING  = 1,
    parameter int WAW_STALL   = 0,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   alloc_valid_i,
    input  logic [AW-1:0]          alloc_rd_i,
    output logic                   alloc_ready_o,
    input  logic [NUM_WB-1:0]      wb_valid_i,
    input  logic [NUM_WB*AW-1:0]   wb_rd_i,
    input  logic [2:0]             rs_valid_i,
    input  logic [3*AW-1:0]        rs_addr_i,
    output logic [2:0]             dep_rs_o,
    output logic [3*NUM_WB-1:0]    fwd_sel_o,
    output logic                   dep_rd_o,
    input  logic                   commit_valid_i,
    input  logic [ID_WIDTH-1:0]    commit_id_i,
    input  logic                   commit_kill_i,
    input  logic                   retire_valid_i,
    input  logic [ID_WIDTH-1:0]    retire_id_i,
    input  logic [ID_WIDTH-1:0]    query_id_i,
    output logic                   id_committed_o,
    output logic                   busy_o,
    output logic                   underflow_o
);

    localparam int CW = $clog2(MAX_PENDING + 1);
    // Wide enough for cnt + inc and for NUM_WB simultaneous retires without wrap.
    localparam int SW = $clog2(MAX_PENDING + NUM_WB + 2);
    localparam int ND = 2 ** ID_WIDTH;

    logic [CW-1:0] cnt_q [NUM_REGS];
    logic [CW-1:0] cnt_d [NUM_REGS];
    logic [SW-1:0] dec_s [NUM_REGS];
    logic [SW-1:0] sum_s;
    logic [SW-1:0] waw_diff_s;
    logic          inc_s;
    logic          uf_s;
    logic          busy_d_s;
    logic          busy_r;
    logic          underflow_r;
    logic [ND-1:0] id_q;
    logic [ND-1:0] id_d;
    logic [AW-1:0] rs_s;
    logic          pend_s;
    logic          found_s;

    // Count writeback ports retiring each register this cycle.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            dec_s[r] = {SW{1'b0}};
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_valid_i[w] && (wb_rd_i[w*AW +: AW] == AW'(r))) begin
                    dec_s[r] = dec_s[r] + SW'(1);
                end else begin
                    dec_s[r] = dec_s[r];
                end
            end
        end
    end

    assign alloc_ready_o = (SW'(cnt_q[alloc_rd_i]) < SW'(MAX_PENDING)) ||
                           (dec_s[alloc_rd_i] != {SW{1'b0}});

    assign waw_diff_s = SW'(cnt_q[alloc_rd_i]) - dec_s[alloc_rd_i];
    assign dep_rd_o   = (WAW_STALL != 0) && (waw_diff_s != {SW{1'b0}});

    // Next counter values, underflow detection and busy summary.
    always_comb begin
        uf_s     = 1'b0;
        busy_d_s = 1'b0;
        sum_s    = {SW{1'b0}};
        inc_s    = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_s = alloc_valid_i && alloc_ready_o && (alloc_rd_i == AW'(r));
            sum_s = SW'(cnt_q[r]) + SW'(inc_s);
            if (dec_s[r] > sum_s) begin
                cnt_d[r] = {CW{1'b0}};
                uf_s     = 1'b1;
            end else begin
                cnt_d[r] = CW'(sum_s - dec_s[r]);
            end
            if (flush_i) begin
                cnt_d[r] = {CW{1'b0}};
            end else begin
                cnt_d[r] = cnt_d[r];
            end
            busy_d_s = busy_d_s || (cnt_d[r] != {CW{1'b0}});
        end
    end

    // RAW check per operand; only a single outstanding write may be forwarded.
    always_comb begin
        fwd_sel_o = {(3*NUM_WB){1'b0}};
        dep_rs_o  = 3'b000;
        rs_s      = {AW{1'b0}};
        pend_s    = 1'b0;
        found_s   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rs_s    = rs_addr_i[i*AW +: AW];
            pend_s  = rs_valid_i[i] && (cnt_q[rs_s] != {CW{1'b0}});
            found_s = 1'b0;
            if ((FORWARDING != 0) && pend_s && (cnt_q[rs_s] == CW'(1))) begin
                for (int w = 0; w < NUM_WB; w++) begin
                    if (!found_s && wb_valid_i[w] && (wb_rd_i[w*AW +: AW] == rs_s)) begin
                        fwd_sel_o[i*NUM_WB + w] = 1'b1;
                        found_s                 = 1'b1;
                    end else begin
                        found_s = found_s;
                    end
                end
            end else begin
                found_s = 1'b0;
            end
            dep_rs_o[i] = pend_s && !found_s;
        end
    end

    // Commit table update; a same-cycle commit beats a retire of the reused ID.
    always_comb begin
        id_d = id_q;
        if (flush_i) begin
            id_d = {ND{1'b0}};
        end else begin
            if (retire_valid_i) begin
                id_d[retire_id_i] = 1'b0;
            end else begin
                id_d = id_d;
            end
            if (commit_valid_i && !commit_kill_i) begin
                id_d[commit_id_i] = 1'b1;
            end else begin
                id_d = id_d;
            end
        end
    end

    assign id_committed_o = id_q[query_id_i] ||
                            (commit_valid_i && !commit_kill_i && (commit_id_i == query_id_i));

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= {CW{1'b0}};
            end
            id_q        <= {ND{1'b0}};
            busy_r      <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            id_q        <= id_d;
            busy_r      <= busy_d_s;
            underflow_r <= underflow_r || (uf_s && !flush_i);
        end
    end

    assign busy_o      = busy_r;
    assign underflow_o = underflow_r;

endmodule

// File: tb/tb_fpu_ss_rd_scoreboard.sv
// Scoreboard bench for fpu_ss_rd_scoreboard: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_fpu_ss_rd_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic [2:0]  rs_valid;
    logic [14:0] rs_addr;
    logic [2:0]  dep_rs;
    logic [5:0]  fwd_sel;
    logic        dep_rd;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic        retire_valid;
    logic [3:0]  retire_id;
    logic [3:0]  query_id;
    logic        id_committed;
    logic        busy;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         sel;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sbq[$];

    fpu_ss_rd_scoreboard #(
        .NUM_REGS(32), .MAX_PENDING(3), .NUM_WB(2), .ID_WIDTH(4),
        .FORWARDING(1), .WAW_STALL(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .alloc_valid_i(alloc_valid), .alloc_rd_i(alloc_rd), .alloc_ready_o(alloc_ready),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .rs_valid_i(rs_valid), .rs_addr_i(rs_addr),
        .dep_rs_o(dep_rs), .fwd_sel_o(fwd_sel), .dep_rd_o(dep_rd),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .retire_valid_i(retire_valid), .retire_id_i(retire_id),
        .query_id_i(query_id), .id_committed_o(id_committed),
        .busy_o(busy), .underflow_o(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_RDY = 0, S_DRS = 1, S_FWD = 2, S_DRD = 3, S_IDC = 4, S_BSY = 5, S_UF = 6;

    function automatic logic [7:0] actual(input int sel);
        case (sel)
            S_RDY:   return {7'd0, alloc_ready};
            S_DRS:   return {5'd0, dep_rs};
            S_FWD:   return {2'd0, fwd_sel};
            S_DRD:   return {7'd0, dep_rd};
            S_IDC:   return {7'd0, id_committed};
            S_BSY:   return {7'd0, busy};
            S_UF:    return {7'd0, underflow};
            default: return 8'hFF;
        endcase
    endfunction

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t e;
            logic [7:0] a;
            e = sbq.pop_front();
            a = actual(e.sel);
            total++;
            if (a !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
            end
        end
    end

    task automatic chk(input int sel, input logic [7:0] exp, input string name);
        exp_t e;
        e.sel = sel; e.exp = exp; e.name = name;
        sbq.push_back(e);
    endtask

    task automatic idle();
        flush = 1'b0; alloc_valid = 1'b0; alloc_rd = 5'd0;
        wb_valid = 2'b00; wb_rd = 10'd0; rs_valid = 3'b000; rs_addr = 15'd0;
        commit_valid = 1'b0; commit_id = 4'd0; commit_kill = 1'b0;
        retire_valid = 1'b0; retire_id = 4'd0; query_id = 4'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic alloc(input logic [4:0] rd);
        cyc();
        alloc_valid = 1'b1; alloc_rd = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk(S_BSY, 8'd0, "reset_busy");
        chk(S_UF,  8'd0, "reset_underflow");
        cyc();
        rst_n = 1'b1;
        chk(S_RDY, 8'd1, "reset_ready");
        chk(S_DRS, 8'd0, "reset_dep_rs");
        chk(S_FWD, 8'd0, "reset_fwd");
        chk(S_DRD, 8'd0, "reset_dep_rd");
        chk(S_IDC, 8'd0, "reset_id");

        // Test 1: fill rd5 to the limit, then a same-cycle retire frees a slot.
        alloc(5'd5); chk(S_RDY, 8'd1, "t1_ready0"); chk(S_DRD, 8'd0, "t1_waw0");
        alloc(5'd5); chk(S_DRD, 8'd1, "t1_waw1"); chk(S_BSY, 8'd1, "t1_busy");
        alloc(5'd5); chk(S_RDY, 8'd1, "t1_ready2");
        alloc(5'd5); chk(S_RDY, 8'd0, "t1_full");
        alloc(5'd5); wb_valid = 2'b01; wb_rd[4:0] = 5'd5;
        chk(S_RDY, 8'd1, "t1_ready_wb"); chk(S_DRD, 8'd1, "t1_waw_wb");
        alloc(5'd5); chk(S_RDY, 8'd0, "t1_still3");
        cyc(); wb_valid = 2'b11; wb_rd = {5'd5, 5'd5};
        cyc(); wb_valid = 2'b01; wb_rd[4:0] = 5'd5; chk(S_BSY, 8'd1, "t1_busy_1left");
        cyc(); alloc_rd = 5'd5;
        chk(S_BSY, 8'd0, "t1_busy_drop"); chk(S_UF, 8'd0, "t1_no_uf");
        chk(S_RDY, 8'd1, "t1_ready_empty"); chk(S_DRD, 8'd0, "t1_waw_empty");

        // Test 2: forwarding only with a single pending write.
        alloc(5'd7);
        cyc(); rs_valid = 3'b010; rs_addr[9:5] = 5'd7; wb_valid = 2'b10; wb_rd[9:5] = 5'd7;
        chk(S_FWD, 8'h08, "t2_fwd_lsu"); chk(S_DRS, 8'd0, "t2_nodep");
        alloc(5'd7);
        alloc(5'd7);
        cyc(); rs_valid = 3'b010; rs_addr[9:5] = 5'd7; wb_valid = 2'b10; wb_rd[9:5] = 5'd7;
        chk(S_FWD, 8'd0, "t2_nofwd_cnt2"); chk(S_DRS, 8'h02, "t2_dep_cnt2");
        cyc(); rs_valid = 3'b101; rs_addr[4:0] = 5'd7; rs_addr[14:10] = 5'd7;
        wb_valid = 2'b01; wb_rd[4:0] = 5'd7;
        chk(S_FWD, 8'h11, "t2_fwd_ops02"); chk(S_DRS, 8'd0, "t2_nodep_ops02");
        cyc(); rs_valid = 3'b111; rs_addr = {5'd7, 5'd7, 5'd7};
        chk(S_DRS, 8'd0, "t2_clear_dep"); chk(S_FWD, 8'd0, "t2_clear_fwd");

        // Test 3: double retire, then underflow with forwarding priority.
        alloc(5'd3);
        alloc(5'd3);
        cyc(); wb_valid = 2'b11; wb_rd = {5'd3, 5'd3}; chk(S_BSY, 8'd1, "t3_busy");
        cyc(); chk(S_BSY, 8'd0, "t3_busy_drop"); chk(S_UF, 8'd0, "t3_no_uf");
        alloc(5'd3);
        cyc(); wb_valid = 2'b11; wb_rd = {5'd3, 5'd3}; rs_valid = 3'b001; rs_addr[4:0] = 5'd3;
        chk(S_FWD, 8'h01, "t3_fwd_prio"); chk(S_DRS, 8'd0, "t3_fwd_nodep");
        cyc(); alloc_rd = 5'd3;
        chk(S_UF, 8'd1, "t3_uf_set"); chk(S_BSY, 8'd0, "t3_busy0");
        chk(S_RDY, 8'd1, "t3_ready"); chk(S_DRD, 8'd0, "t3_waw0");

        // Test 4: WAW hazard cleared by a same-cycle retire.
        alloc(5'd9);
        cyc(); alloc_rd = 5'd9; chk(S_DRD, 8'd1, "t4_waw");
        alloc(5'd9); wb_valid = 2'b01; wb_rd[4:0] = 5'd9;
        chk(S_DRD, 8'd0, "t4_waw_wb"); chk(S_RDY, 8'd1, "t4_ready");
        cyc(); wb_valid = 2'b01; wb_rd[4:0] = 5'd9;
        cyc(); alloc_rd = 5'd9; chk(S_DRD, 8'd0, "t4_empty");

        // Test 5: commit table.
        cyc(); commit_valid = 1'b1; commit_id = 4'd4; commit_kill = 1'b1; query_id = 4'd4;
        chk(S_IDC, 8'd0, "t5_kill_same");
        cyc(); query_id = 4'd4; chk(S_IDC, 8'd0, "t5_kill_after");
        cyc(); commit_valid = 1'b1; commit_id = 4'd4; query_id = 4'd4;
        chk(S_IDC, 8'd1, "t5_commit_same");
        cyc(); query_id = 4'd4; chk(S_IDC, 8'd1, "t5_commit_after");
        cyc(); query_id = 4'd5; chk(S_IDC, 8'd0, "t5_other_id");
        cyc(); commit_valid = 1'b1; commit_id = 4'd4; retire_valid = 1'b1; retire_id = 4'd4;
        query_id = 4'd4; chk(S_IDC, 8'd1, "t5_both_same");
        cyc(); query_id = 4'd4; chk(S_IDC, 8'd1, "t5_commit_wins");
        cyc(); retire_valid = 1'b1; retire_id = 4'd4; query_id = 4'd4;
        chk(S_IDC, 8'd1, "t5_retire_same");
        cyc(); query_id = 4'd4; chk(S_IDC, 8'd0, "t5_retired");

        // Test 6: flush dominates, then async reset mid-burst.
        alloc(5'd1); commit_valid = 1'b1; commit_id = 4'd7;
        alloc(5'd2); commit_valid = 1'b1; commit_id = 4'd8;
        alloc(5'd1); flush = 1'b1; commit_valid = 1'b1; commit_id = 4'd9;
        chk(S_RDY, 8'd1, "t6_ready_preflush"); chk(S_BSY, 8'd1, "t6_busy_pre");
        cyc(); query_id = 4'd7; alloc_rd = 5'd1; rs_valid = 3'b011; rs_addr[4:0] = 5'd1;
        rs_addr[9:5] = 5'd2;
        chk(S_BSY, 8'd0, "t6_busy_flushed"); chk(S_IDC, 8'd0, "t6_id7_flushed");
        chk(S_DRD, 8'd0, "t6_waw_flushed"); chk(S_DRS, 8'd0, "t6_dep_flushed");
        chk(S_UF, 8'd1, "t6_uf_kept");
        cyc(); query_id = 4'd9; chk(S_IDC, 8'd0, "t6_id9_dropped");
        cyc(); query_id = 4'd8; chk(S_IDC, 8'd0, "t6_id8_flushed");
        alloc(5'd4); commit_valid = 1'b1; commit_id = 4'd2;
        alloc(5'd4); rst_n = 1'b0;
        chk(S_BSY, 8'd0, "t6_rst_busy"); chk(S_UF, 8'd0, "t6_rst_uf");
        cyc();
        cyc(); rst_n = 1'b1; query_id = 4'd2; alloc_rd = 5'd4;
        chk(S_IDC, 8'd0, "t6_post_id"); chk(S_DRD, 8'd0, "t6_post_waw");
        chk(S_BSY, 8'd0, "t6_post_busy"); chk(S_UF, 8'd0, "t6_post_uf");
        chk(S_RDY, 8'd1, "t6_post_ready");

        cyc();
        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
